// File: rtl/exwb_stage.sv
// Execute->writeback stage: 2-entry in-order buffer feeding the register-file write port,
// retirement-time N/Z status and retired-op counter. Optional forwarding lookup under EXWB_FWD_EN.
module exwb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iValid,
    output logic              oReady,
    input  logic [DATA_W-1:0] iResult,
    input  logic              iNeg,
    input  logic              iZero,
    input  logic [REG_AW-1:0] iDest,
    input  logic              iWrEn,
    input  logic              iSetFlags,
    output logic              oWbValid,
    input  logic              iWbReady,
    output logic [DATA_W-1:0] oWbData,
    output logic [REG_AW-1:0] oWbDest,
    output logic              oWbWrEn,
    output logic              oFlagN,
    output logic              oFlagZ,
    output logic [CNT_W-1:0]  oRetireCnt,
    input  logic [REG_AW-1:0] iFwdAddr,
    output logic              oFwdHit,
    output logic [DATA_W-1:0] oFwdData
);

    // Slot 0 is always the head; slot 1 is the tail when two entries are held.
    logic [1:0]        count_reg;
    logic [1:0]        count_next;
    logic [DATA_W-1:0] data_reg [2];
    logic [REG_AW-1:0] dest_reg [2];
    logic [1:0]        neg_reg;
    logic [1:0]        zero_reg;
    logic [1:0]        wren_reg;
    logic [1:0]        setf_reg;
    logic              flag_n_reg;
    logic              flag_z_reg;
    logic [CNT_W-1:0]  retire_cnt_reg;

    logic              push;
    logic              pop;
    logic              wr_idx;
    logic [1:0]        wr_sel;

    assign oReady   = (count_reg != 2'd2);
    assign oWbValid = (count_reg != 2'd0);
    assign push     = iValid & oReady;
    assign pop      = oWbValid & iWbReady;

    // With a simultaneous pop the head vacates, so the new entry lands one slot lower.
    assign wr_idx = (count_reg == 2'd1) & ~pop;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_wr_sel
            assign wr_sel[gi] = push & (wr_idx == gi[0]);
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            count_reg <= 2'd0;
        end else begin
            count_reg <= count_next;
        end
    end

    // Entry payload needs no reset: it is only observed while count marks it valid.
    always_ff @(posedge iClk) begin
        if (wr_sel[0]) begin
            data_reg[0] <= iResult;
            dest_reg[0] <= iDest;
            neg_reg[0]  <= iNeg;
            zero_reg[0] <= iZero;
            wren_reg[0] <= iWrEn;
            setf_reg[0] <= iSetFlags;
        end else if (pop) begin
            data_reg[0] <= data_reg[1];
            dest_reg[0] <= dest_reg[1];
            neg_reg[0]  <= neg_reg[1];
            zero_reg[0] <= zero_reg[1];
            wren_reg[0] <= wren_reg[1];
            setf_reg[0] <= setf_reg[1];
        end
        if (wr_sel[1]) begin
            data_reg[1] <= iResult;
            dest_reg[1] <= iDest;
            neg_reg[1]  <= iNeg;
            zero_reg[1] <= iZero;
            wren_reg[1] <= iWrEn;
            setf_reg[1] <= iSetFlags;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            flag_n_reg     <= 1'b0;
            flag_z_reg     <= 1'b0;
            retire_cnt_reg <= '0;
        end else if (pop) begin
            if (setf_reg[0]) begin
                flag_n_reg <= neg_reg[0];
                flag_z_reg <= zero_reg[0];
            end
            retire_cnt_reg <= retire_cnt_reg + 1'b1;
        end
    end

    assign oWbData    = data_reg[0];
    assign oWbDest    = dest_reg[0];
    assign oWbWrEn    = wren_reg[0] & (dest_reg[0] != '0);
    assign oFlagN     = flag_n_reg;
    assign oFlagZ     = flag_z_reg;
    assign oRetireCnt = retire_cnt_reg;

`ifdef EXWB_FWD_EN
    logic [1:0] fwd_match;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_match[gi] = (count_reg > gi[1:0]) & wren_reg[gi]
                                 & (dest_reg[gi] != '0) & (dest_reg[gi] == iFwdAddr);
        end
    endgenerate

    // Tail is younger than head, so it wins when both match.
    always_comb begin
        oFwdHit  = |fwd_match;
        oFwdData = '0;
        if (fwd_match[1]) begin
            oFwdData = data_reg[1];
        end else if (fwd_match[0]) begin
            oFwdData = data_reg[0];
        end
    end
`else
    logic unused_fwd_addr;
    assign unused_fwd_addr = ^iFwdAddr;
    assign oFwdHit         = 1'b0;
    assign oFwdData        = '0;
`endif

endmodule

// File: tb/tb_exwb_stage.sv
// Bench for exwb_stage: directed vector table, hand-written corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_exwb_stage;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iValid;
    logic        oReady;
    logic [31:0] iResult;
    logic        iNeg;
    logic        iZero;
    logic [4:0]  iDest;
    logic        iWrEn;
    logic        iSetFlags;
    logic        oWbValid;
    logic        iWbReady;
    logic [31:0] oWbData;
    logic [4:0]  oWbDest;
    logic        oWbWrEn;
    logic        oFlagN;
    logic        oFlagZ;
    logic [15:0] oRetireCnt;
    logic [4:0]  iFwdAddr;
    logic        oFwdHit;
    logic [31:0] oFwdData;

    always #5 iClk = ~iClk;

    exwb_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dut (
        .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(oReady),
        .iResult(iResult), .iNeg(iNeg), .iZero(iZero), .iDest(iDest),
        .iWrEn(iWrEn), .iSetFlags(iSetFlags), .oWbValid(oWbValid),
        .iWbReady(iWbReady), .oWbData(oWbData), .oWbDest(oWbDest),
        .oWbWrEn(oWbWrEn), .oFlagN(oFlagN), .oFlagZ(oFlagZ),
        .oRetireCnt(oRetireCnt), .iFwdAddr(iFwdAddr), .oFwdHit(oFwdHit),
        .oFwdData(oFwdData)
    );

    typedef struct {
        logic [31:0] res;
        logic        neg;
        logic        zero;
        logic [4:0]  dest;
        logic        wren;
        logic        setf;
    } ent_t;

    typedef struct {
        logic        v;
        logic [31:0] res;
        logic [4:0]  dest;
        logic        wbr;
        logic        e_rdy;
        logic        e_wbv;
        logic [31:0] e_data;
        logic [4:0]  e_dest;
        logic        e_wren;
        logic [15:0] e_cnt;
    } vec_t;

    ent_t q[$];
    logic m_n;
    logic m_z;
    int   m_cnt;
    int   checks = 0;
    int   errors = 0;
`ifdef EXWB_FWD_EN
    localparam logic FWD_ON = 1'b1;
`else
    localparam logic FWD_ON = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic        mhit;
        logic [31:0] mdata;
        #2;
        mhit  = 1'b0;
        mdata = 32'h0;
        if (FWD_ON) begin
            foreach (q[i]) begin
                if (q[i].wren && q[i].dest != 5'd0 && q[i].dest == iFwdAddr) begin
                    mhit  = 1'b1;
                    mdata = q[i].res;
                end
            end
        end
        check({tag, ".ready"}, {31'b0, oReady}, {31'b0, q.size() < 2});
        check({tag, ".wbvalid"}, {31'b0, oWbValid}, {31'b0, q.size() != 0});
        if (q.size() != 0) begin
            check({tag, ".wbdata"}, oWbData, q[0].res);
            check({tag, ".wbdest"}, {27'b0, oWbDest}, {27'b0, q[0].dest});
            check({tag, ".wbwren"}, {31'b0, oWbWrEn}, {31'b0, q[0].wren && q[0].dest != 5'd0});
        end
        check({tag, ".flagn"}, {31'b0, oFlagN}, {31'b0, m_n});
        check({tag, ".flagz"}, {31'b0, oFlagZ}, {31'b0, m_z});
        check({tag, ".cnt"}, {16'b0, oRetireCnt}, m_cnt);
        check({tag, ".fwdhit"}, {31'b0, oFwdHit}, {31'b0, mhit});
        check({tag, ".fwddata"}, oFwdData, mdata);
    endtask

    // Advance one clock; the model follows the handshake rules on the inputs seen at the edge.
    task automatic step();
        logic push;
        logic pop;
        ent_t e;
        ent_t h;
        push = iValid && (q.size() < 2);
        pop  = (q.size() != 0) && iWbReady;
        e    = '{iResult, iNeg, iZero, iDest, iWrEn, iSetFlags};
        @(posedge iClk);
        if (iRst) begin
            q.delete();
            m_n   = 1'b0;
            m_z   = 1'b0;
            m_cnt = 0;
        end else begin
            if (pop) begin
                h = q.pop_front();
                if (h.setf) begin
                    m_n = h.neg;
                    m_z = h.zero;
                end
                m_cnt = (m_cnt + 1) % 65536;
            end
            if (push) q.push_back(e);
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] res, input logic neg, input logic zero,
                         input logic [4:0] dest, input logic wren, input logic setf, input logic wbr);
        iValid    = v;
        iResult   = res;
        iNeg      = neg;
        iZero     = zero;
        iDest     = dest;
        iWrEn     = wren;
        iSetFlags = setf;
        iWbReady  = wbr;
    endtask

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1'b1, 32'h05, 5'd3, 1'b1, 1'b1, 1'b0, 32'h00, 5'd0, 1'b0, 16'd0};
        tbl[1] = '{1'b0, 32'h00, 5'd0, 1'b1, 1'b1, 1'b1, 32'h05, 5'd3, 1'b1, 16'd0};
        tbl[2] = '{1'b0, 32'h00, 5'd0, 1'b0, 1'b1, 1'b0, 32'h00, 5'd0, 1'b0, 16'd1};
        tbl[3] = '{1'b1, 32'h11, 5'd4, 1'b0, 1'b1, 1'b0, 32'h00, 5'd0, 1'b0, 16'd1};
        tbl[4] = '{1'b1, 32'h22, 5'd5, 1'b0, 1'b1, 1'b1, 32'h11, 5'd4, 1'b1, 16'd1};
        tbl[5] = '{1'b1, 32'h33, 5'd6, 1'b0, 1'b0, 1'b1, 32'h11, 5'd4, 1'b1, 16'd1};
        tbl[6] = '{1'b1, 32'h33, 5'd6, 1'b1, 1'b0, 1'b1, 32'h11, 5'd4, 1'b1, 16'd1};
        tbl[7] = '{1'b1, 32'h33, 5'd6, 1'b1, 1'b1, 1'b1, 32'h22, 5'd5, 1'b1, 16'd2};
        tbl[8] = '{1'b0, 32'h00, 5'd0, 1'b1, 1'b1, 1'b1, 32'h33, 5'd6, 1'b1, 16'd3};
        tbl[9] = '{1'b0, 32'h00, 5'd0, 1'b1, 1'b1, 1'b0, 32'h00, 5'd0, 1'b0, 16'd4};

        m_n = 1'b0; m_z = 1'b0; m_cnt = 0;
        iFwdAddr = 5'd0;
        drive(1'b1, 32'hDEAD, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1, 1'b1);
        iRst = 1'b1;
        step();
        step();
        iRst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_model("reset0");

        // Single op and backpressure vectors
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v, tbl[i].res, 1'b0, 1'b0, tbl[i].dest, 1'b1, 1'b0, tbl[i].wbr);
            #2;
            check($sformatf("vec%0d.ready", i), {31'b0, oReady}, {31'b0, tbl[i].e_rdy});
            check($sformatf("vec%0d.wbvalid", i), {31'b0, oWbValid}, {31'b0, tbl[i].e_wbv});
            check($sformatf("vec%0d.cnt", i), {16'b0, oRetireCnt}, {16'b0, tbl[i].e_cnt});
            if (tbl[i].e_wbv) begin
                check($sformatf("vec%0d.data", i), oWbData, tbl[i].e_data);
                check($sformatf("vec%0d.dest", i), {27'b0, oWbDest}, {27'b0, tbl[i].e_dest});
                check($sformatf("vec%0d.wren", i), {31'b0, oWbWrEn}, {31'b0, tbl[i].e_wren});
            end
            step();
        end

        // Flags set on retirement, then held by a non-flag-setting op
        drive(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        #2;
        check("flags.before_retire_n", {31'b0, oFlagN}, 32'd0);
        step();
        #2;
        check("flags.set_n", {31'b0, oFlagN}, 32'd1);
        check("flags.set_z", {31'b0, oFlagZ}, 32'd0);
        drive(1'b1, 32'h0, 1'b0, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        step();
        #2;
        check("flags.hold_n", {31'b0, oFlagN}, 32'd1);
        check("flags.hold_z", {31'b0, oFlagZ}, 32'd0);

        // Register 0 is never written
        drive(1'b1, 32'hABCD, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #2;
        check("r0.wbvalid", {31'b0, oWbValid}, 32'd1);
        check("r0.wbwren", {31'b0, oWbWrEn}, 32'd0);
        check("r0.wbdata", oWbData, 32'hABCD);
        iWbReady = 1'b1;
        step();

        // Forwarding from two stalled entries to the same register
        drive(1'b1, 32'h11, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h22, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        iFwdAddr = 5'd7;
        #2;
        check("fwd7.hit", {31'b0, oFwdHit}, {31'b0, FWD_ON});
        check("fwd7.data", oFwdData, FWD_ON ? 32'h22 : 32'h0);
        iFwdAddr = 5'd0;
        #2;
        check("fwd0.hit", {31'b0, oFwdHit}, 32'd0);
        check_model("fwd");
        iWbReady = 1'b1;
        step();
        step();

        // Reset with a full buffer, set flags and a coincident handshake
        drive(1'b1, 32'h0, 1'b1, 1'b1, 5'd1, 1'b1, 1'b1, 1'b1);
        step();
        drive(1'b1, 32'h44, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        step();
        step();
        drive(1'b1, 32'h55, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b1);
        iRst = 1'b1;
        step();
        iRst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        #2;
        check("rst.ready", {31'b0, oReady}, 32'd1);
        check("rst.wbvalid", {31'b0, oWbValid}, 32'd0);
        check("rst.flagn", {31'b0, oFlagN}, 32'd0);
        check("rst.flagz", {31'b0, oFlagZ}, 32'd0);
        check("rst.cnt", {16'b0, oRetireCnt}, 32'd0);
        step();
        step();
        #2;
        check("rst.no_retire", {16'b0, oRetireCnt}, 32'd0);
        check("rst.still_empty", {31'b0, oWbValid}, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            iRst      = ($urandom_range(0, 199) == 0);
            iValid    = $urandom_range(0, 1);
            iResult   = $urandom;
            iNeg      = $urandom_range(0, 1);
            iZero     = $urandom_range(0, 1);
            iDest     = 5'($urandom_range(0, 7));
            iWrEn     = $urandom_range(0, 1);
            iSetFlags = $urandom_range(0, 1);
            iWbReady  = $urandom_range(0, 1);
            iFwdAddr  = 5'($urandom_range(0, 7));
            check_model("rnd");
            step();
        end
        iRst = 1'b0;

        // Stream ops until the counter reaches its top value, then wrap it
        begin
            int guard;
            guard = 0;
            iWbReady = 1'b1;
            iWrEn    = 1'b1;
            iDest    = 5'd3;
            while (m_cnt != 65535 && guard < 70000) begin
                iValid  = ((m_cnt + q.size()) < 65535);
                iResult = guard;
                step();
                guard++;
            end
            if (guard >= 70000) begin
                errors++;
                $display("FAIL wrap.timeout actual=%0d required=65535", m_cnt);
            end
        end
        iValid = 1'b0;
        #2;
        check("wrap.top", {16'b0, oRetireCnt}, 32'h0000FFFF);
        check_model("wrap.pre");
        iValid = 1'b1;
        step();
        iValid = 1'b0;
        step();
        #2;
        check("wrap.zero", {16'b0, oRetireCnt}, 32'd0);
        check_model("wrap.post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
